demux2_slice: RTL and testbench
===============================

DEMUX2_SLICE -- requirements
Module: demux2_slice

Interface
REQ-001 Parameter: WIDTH, default 32, data path width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream word present.
REQ-005 in_sel  input  1  destination select: 0 routes to port 0, 1 routes to port 1.
REQ-006 in_data  input  WIDTH  upstream word.
REQ-007 in_ready  output  1  upstream word accepted this cycle when in_valid is also high.
REQ-008 out0_valid / out1_valid  output  1  port holds a word.
REQ-009 out0_data / out1_data  output  WIDTH  held word.
REQ-010 out0_ready / out1_ready  input  1  sink consumes the held word this cycle when valid is also high.
REQ-011 (STAT build only) cnt0 / cnt1  output  32  count of words delivered per port.

Function
REQ-012 Each port SHALL be a one-entry register slice with states EMPTY (outN_valid=0) and FULL (outN_valid=1).
REQ-013 in_ready SHALL equal (~outN_valid | outN_ready) for N = in_sel, and SHALL be combinational on in_sel, outN_valid and outN_ready only, never on in_valid.
REQ-014 An accept (in_valid & in_ready) SHALL load in_data into port in_sel and set it FULL on the next edge: latency 1 cycle, no combinational in-to-out data path.
REQ-015 A drain (outN_valid & outN_ready) without a load to the same port SHALL move the port to EMPTY.
REQ-016 A simultaneous drain and load on the same port SHALL keep it FULL with the new word: full throughput, 1 word per cycle.
REQ-017 The non-selected port SHALL drain independently in the same cycle; both ports MAY drain in one cycle.
REQ-018 A FULL port with outN_ready=0 SHALL hold outN_data and outN_valid stable, and SHALL stall only inputs selecting it.
REQ-019 in_sel and in_data SHALL be ignored when in_valid=0; no state change.
REQ-020 Words to the same port SHALL be delivered in acceptance order; there is no ordering between ports.

Reset
REQ-021 resetn=0 SHALL force both ports EMPTY, outN_data to 0 and cnt0/cnt1 to 0 asynchronously, regardless of in-flight words.
REQ-022 A word held at reset assertion SHALL be discarded and never presented after release.
REQ-023 On the first edge after resetn deasserts, in_ready SHALL be 1 for either in_sel value.

Configuration
REQ-024 Macro DEMUX2_SLICE_STAT_EN: when defined, cnt0 and cnt1 SHALL exist.
REQ-025 With DEMUX2_SLICE_STAT_EN defined, cntN SHALL increment by 1 on each drain of port N and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-026 Without DEMUX2_SLICE_STAT_EN, the cnt ports and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Reset release, then in_valid=1, sel=0, data=32'hDEADBEEF, out0_ready=1 -> the next cycle out0_valid=1 and out0_data=32'hDEADBEEF; out1_valid stays 0.
REQ-028 Back-to-back stream 1,2,3,4 to port 1 with out1_ready=1 -> in_ready is 1 every cycle and out1_data is 1,2,3,4 on consecutive cycles.
REQ-029 Port 0 FULL with out0_ready=0, then input sel=0 -> in_ready=0 and out0_data holds; switch to sel=1 with data=32'h5 -> accepted, out1_data=32'h5.
REQ-030 FULL port 0 holding 32'hA, with drain and load of 32'hB in the same cycle -> next cycle out0_valid=1 and out0_data=32'hB; no bubble.
REQ-031 resetn pulsed low mid-stream while both ports are FULL -> both valids drop immediately, data reads 0, and no old word reappears.
REQ-032 STAT build, counter preloaded near 32'hFFFFFFFF by driving drains, then 2 more drains on port 1 -> cnt1 wraps to 32'h1 while cnt0 is unchanged.

Source files
------------

// File: rtl/demux2_slice.sv
// 1:2 demultiplexer with a one-entry register slice on each output port.
// Define DEMUX2_SLICE_STAT_EN to add per-port delivered-word counters cnt0/cnt1.
module demux2_slice #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready
`ifdef DEMUX2_SLICE_STAT_EN
  ,
  output logic [31:0]      cnt0,
  output logic [31:0]      cnt1
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state0_q, state0_d;
  slot_state_e      state1_q, state1_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;

  logic drain0, drain1;
  logic load0, load1;

  assign out0_valid = (state0_q == FULL);
  assign out1_valid = (state1_q == FULL);
  assign out0_data  = data0_q;
  assign out1_data  = data1_q;

  assign drain0 = out0_valid & out0_ready;
  assign drain1 = out1_valid & out1_ready;

  // Ready looks only at the selected slot, so a stalled port never blocks the other.
  assign in_ready = in_sel ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready);

  assign load0 = in_valid & in_ready & ~in_sel;
  assign load1 = in_valid & in_ready &  in_sel;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state0_d = state0_q;
    state1_d = state1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;

    // A load wins over a drain: the slot refills in the same cycle it empties.
    if (load0) begin
      state0_d = FULL;
      data0_d  = in_data;
    end else if (drain0) begin
      state0_d = EMPTY;
    end

    if (load1) begin
      state1_d = FULL;
      data1_d  = in_data;
    end else if (drain1) begin
      state1_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state0_q <= EMPTY;
      state1_q <= EMPTY;
      // NOTE: data registers are cleared too so a discarded word can never be observed.
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state0_q <= state0_d;
      state1_q <= state1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
    end
  end

`ifdef DEMUX2_SLICE_STAT_EN
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;

  // Counters wrap naturally at 2^32.
  assign cnt0_d = cnt0_q + {31'd0, drain0};
  assign cnt1_d = cnt1_q + {31'd0, drain1};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_slice.sv
// Self-checking bench for demux2_slice: directed scenarios, then random traffic
// against a queue-based model of the two output slots.
module tb_demux2_slice;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out0_valid;
  logic [WIDTH-1:0] out0_data;
  logic             out0_ready;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;
  logic             out1_ready;
`ifdef DEMUX2_SLICE_STAT_EN
  logic [31:0]      cnt0;
  logic [31:0]      cnt1;
`endif

  always #5 clk = ~clk;

  demux2_slice #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready)
`ifdef DEMUX2_SLICE_STAT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  // Reference model: each port is a queue of accepted, not yet delivered words.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  int unsigned      mcnt0, mcnt1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ready(input logic sel);
    if (sel) return (q1.size() == 0) || out1_ready;
    return (q0.size() == 0) || out0_ready;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".ready"}, 64'(in_ready), 64'(model_ready(in_sel)));
    check({tag, ".v0"}, 64'(out0_valid), 64'(q0.size() != 0));
    check({tag, ".v1"}, 64'(out1_valid), 64'(q1.size() != 0));
    if (q0.size() != 0) check({tag, ".d0"}, 64'(out0_data), 64'(q0[0]));
    if (q1.size() != 0) check({tag, ".d1"}, 64'(out1_data), 64'(q1[0]));
`ifdef DEMUX2_SLICE_STAT_EN
    check({tag, ".cnt0"}, 64'(cnt0), 64'(mcnt0));
    check({tag, ".cnt1"}, 64'(cnt1), 64'(mcnt1));
`endif
  endtask

  task automatic model_edge();
    logic acc;
    acc = in_valid && model_ready(in_sel);
    if (q0.size() != 0 && out0_ready) begin
      void'(q0.pop_front());
      mcnt0++;
    end
    if (q1.size() != 0 && out1_ready) begin
      void'(q1.pop_front());
      mcnt1++;
    end
    if (acc) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
    end
  endtask

  // Drive one cycle: inputs set after the falling edge, model compared before the
  // rising edge, model advanced at the edge; returns #1 after the rising edge.
  task automatic drive(input string tag, input logic v, input logic s,
                       input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    @(negedge clk);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    compare_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    mcnt0 = 0;
    mcnt1 = 0;
  endtask

  // Asynchronous reset pulse applied away from any clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check({tag, ".v0"}, 64'(out0_valid), 64'd0);
    check({tag, ".v1"}, 64'(out1_valid), 64'd0);
    check({tag, ".d0"}, 64'(out0_data), 64'd0);
    check({tag, ".d1"}, 64'(out1_data), 64'd0);
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    in_sel = 1'b0;
    #1;
    check({tag, ".rdy_sel0"}, 64'(in_ready), 64'd1);
    in_sel = 1'b1;
    #1;
    check({tag, ".rdy_sel1"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    resetn     = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    model_reset();

    pulse_reset("init_rst");

    // Single word to port 0.
    drive("req027", 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    check("req027.v0", 64'(out0_valid), 64'd1);
    check("req027.d0", 64'(out0_data), 64'hDEADBEEF);
    check("req027.v1", 64'(out1_valid), 64'd0);

    // Back-to-back stream to port 1.
    for (int i = 1; i <= 4; i++) begin
      drive("req028", 1'b1, 1'b1, WIDTH'(i), 1'b1, 1'b1);
      check("req028.d1", 64'(out1_data), 64'(i));
    end

    // Port 0 stalled: only inputs selecting port 0 are blocked.
    drive("req029.fill", 1'b1, 1'b0, 32'hA0, 1'b0, 1'b0);
    drive("req029.stall", 1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
    check("req029.hold_d0", 64'(out0_data), 64'hA0);
    drive("req029.other", 1'b1, 1'b1, 32'h5, 1'b0, 1'b1);
    check("req029.d1", 64'(out1_data), 64'h5);
    check("req029.d0_still", 64'(out0_data), 64'hA0);

    // Drain and load of the same port in one cycle.
    drive("req030.a", 1'b1, 1'b0, 32'hA, 1'b1, 1'b0);
    check("req030.dA", 64'(out0_data), 64'hA);
    drive("req030.b", 1'b1, 1'b0, 32'hB, 1'b1, 1'b0);
    check("req030.v0", 64'(out0_valid), 64'd1);
    check("req030.dB", 64'(out0_data), 64'hB);

    // Ignored input when in_valid is low.
    drive("req019", 1'b0, 1'b1, 32'h1234, 1'b0, 1'b1);
    check("req019.v1", 64'(out1_valid), 64'd0);

    // Both ports full, then reset mid-stream.
    drive("req031.fill1", 1'b1, 1'b1, 32'hC, 1'b0, 1'b0);
    check("req031.both", 64'({out0_valid, out1_valid}), 64'b11);
    pulse_reset("req031.rst");
    drive("req031.after", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("req031.v0_after", 64'(out0_valid), 64'd0);
    check("req031.v1_after", 64'(out1_valid), 64'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset("rand_rst");
      drive("rand",
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            WIDTH'($urandom()),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 2) != 0));
    end

    @(negedge clk);
    #1;
    compare_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
